// File: rtl/text_ram_arbiter_if.sv
// Bundle of requester, RAM and debug signals shared by the text RAM arbiter.
// slave: the arbiter; master: requesters plus the RAM.
interface text_ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int LINE_W = 2560
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [LINE_W-1:0] disp_rdata;

  logic              ed_req;
  logic              ed_we;
  logic [ADDR_W-1:0] ed_addr;
  logic [LINE_W-1:0] ed_wdata;
  logic              ed_gnt;
  logic              ed_rvalid;
  logic [LINE_W-1:0] ed_rdata;

  logic [ADDR_W-1:0] ram_address;
  logic              ram_wren;
  logic [LINE_W-1:0] ram_data;
  logic [LINE_W-1:0] ram_q;

  logic [3:0]        starve_cnt;

  modport slave (
    input  disp_req, disp_addr, ed_req, ed_we, ed_addr, ed_wdata, ram_q,
    output disp_gnt, disp_rvalid, disp_rdata, ed_gnt, ed_rvalid, ed_rdata,
           ram_address, ram_wren, ram_data, starve_cnt
  );

  modport master (
    output disp_req, disp_addr, ed_req, ed_we, ed_addr, ed_wdata, ram_q,
    input  disp_gnt, disp_rvalid, disp_rdata, ed_gnt, ed_rvalid, ed_rdata,
           ram_address, ram_wren, ram_data, starve_cnt
  );
endinterface

// File: rtl/text_ram_arbiter.sv
// Arbitrates the single-port line RAM between the display fetcher (D, priority)
// and the editor (E, starvation-protected); tags reads so results reach their owner.
module text_ram_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int LINE_W       = 2560,
  parameter int RAM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  text_ram_arbiter_if.slave   bus
);

  localparam logic OWNER_D    = 1'b0;
  localparam logic OWNER_E    = 1'b1;
  localparam int   TAG_STAGES = RAM_LATENCY + 1;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

  logic              disp_win;
  logic              ed_win;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic              ram_wren_q, ram_wren_d;
  logic [LINE_W-1:0] ram_data_q, ram_data_d;
  tag_t              tag_in;
  tag_t              tag_q [TAG_STAGES];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    disp_win = 1'b0;
    ed_win   = 1'b0;
    if (!rst) begin
      if (bus.ed_req && (!bus.disp_req || starve_cnt_q == LIMIT)) begin
        ed_win = 1'b1;
      end else if (bus.disp_req) begin
        disp_win = 1'b1;
      end
    end
  end

  assign bus.disp_gnt = disp_win;
  assign bus.ed_gnt   = ed_win;

  // A dropped or granted request restarts the wait count from zero.
  always_comb begin
    starve_cnt_d = '0;
    if (bus.ed_req && !ed_win) begin
      starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 4'd1;
    end
  end

  always_comb begin
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = 1'b0;
    tag_in        = '{valid: 1'b0, owner: OWNER_D};
    if (disp_win) begin
      ram_address_d = bus.disp_addr;
      tag_in        = '{valid: 1'b1, owner: OWNER_D};
    end else if (ed_win) begin
      ram_address_d = bus.ed_addr;
      if (bus.ed_we) begin
        ram_wren_d = 1'b1;
        ram_data_d = bus.ed_wdata;
      end else begin
        tag_in     = '{valid: 1'b1, owner: OWNER_E};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order. All state, tag
  // pipeline included, is reset so in-flight reads are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q  <= '0;
      ram_address_q <= '0;
      ram_wren_q    <= 1'b0;
      ram_data_q    <= '0;
      for (int i = 0; i < TAG_STAGES; i++) begin
        tag_q[i] <= '{valid: 1'b0, owner: OWNER_D};
      end
    end else begin
      starve_cnt_q  <= starve_cnt_d;
      ram_address_q <= ram_address_d;
      ram_wren_q    <= ram_wren_d;
      ram_data_q    <= ram_data_d;
      tag_q[0]      <= tag_in;
      for (int i = 1; i < TAG_STAGES; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // The last tag stage lines up with ram_q for the read granted RAM_LATENCY+1 cycles ago.
  assign bus.disp_rvalid = tag_q[RAM_LATENCY].valid && (tag_q[RAM_LATENCY].owner == OWNER_D);
  assign bus.ed_rvalid   = tag_q[RAM_LATENCY].valid && (tag_q[RAM_LATENCY].owner == OWNER_E);
  assign bus.disp_rdata  = bus.ram_q;
  assign bus.ed_rdata    = bus.ram_q;

  assign bus.ram_address = ram_address_q;
  assign bus.ram_wren    = ram_wren_q;
  assign bus.ram_data    = ram_data_q;
  assign bus.starve_cnt  = starve_cnt_q;

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Directed bench for text_ram_arbiter with a 2-cycle-latency line RAM model.
// Cycle c starts 1 time unit after a rising edge; outputs are sampled on the falling edge.
module tb_text_ram_arbiter;
  localparam int ADDR_W       = 8;
  localparam int LINE_W       = 2560;
  localparam int RAM_LATENCY  = 2;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  text_ram_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  text_ram_arbiter #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W),
    .RAM_LATENCY(RAM_LATENCY), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Unwritten lines read back a pattern derived from their address.
  function automatic logic [LINE_W-1:0] line_pat(input logic [7:0] a);
    return {80{a, 8'hA5, ~a, 8'h3C}};
  endfunction

  logic [LINE_W-1:0] mem [256];
  bit   [255:0]      written;
  logic [LINE_W-1:0] rd1, rd2;

  always @(posedge clk) begin
    if (bus.ram_wren) begin
      mem[bus.ram_address]     <= bus.ram_data;
      written[bus.ram_address] <= 1'b1;
    end
    rd1 <= written[bus.ram_address] ? mem[bus.ram_address] : line_pat(bus.ram_address);
    rd2 <= rd1;
  end
  assign bus.ram_q = rd2;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.disp_req  = 1'b0;
    bus.disp_addr = '0;
    bus.ed_req    = 1'b0;
    bus.ed_we     = 1'b0;
    bus.ed_addr   = '0;
    bus.ed_wdata  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    bus.disp_req = 1'b1;
    bus.ed_req   = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.disp_gnt !== 1'b0) $display("FAIL reset disp_gnt: got %b want 0", bus.disp_gnt); else n_pass++;
    n_checks++; if (bus.ed_gnt !== 1'b0) $display("FAIL reset ed_gnt: got %b want 0", bus.ed_gnt); else n_pass++;
    next_cycle();
    rst = 1'b0;
    set_idle();
    @(negedge clk);
    n_checks++; if (bus.ram_wren !== 1'b0) $display("FAIL reset ram_wren: got %b want 0", bus.ram_wren); else n_pass++;
    n_checks++; if (bus.ram_address !== 8'h00) $display("FAIL reset ram_address: got %h want 00", bus.ram_address); else n_pass++;
    n_checks++; if (bus.ram_data !== '0) $display("FAIL reset ram_data: got %h want 0", bus.ram_data[63:0]); else n_pass++;
    n_checks++; if (bus.starve_cnt !== 4'd0) $display("FAIL reset starve_cnt: got %0d want 0", bus.starve_cnt); else n_pass++;
    n_checks++; if ({bus.disp_rvalid, bus.ed_rvalid} !== 2'b00) $display("FAIL reset rvalid: got %b want 00", {bus.disp_rvalid, bus.ed_rvalid}); else n_pass++;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_single_read();
    for (int c = 0; c < 6; c++) begin
      set_idle();
      bus.disp_req  = (c == 0);
      bus.disp_addr = 8'h05;
      @(negedge clk);
      n_checks++; if (bus.disp_gnt !== (c == 0)) $display("FAIL single_read disp_gnt c%0d: got %b want %b", c, bus.disp_gnt, c == 0); else n_pass++;
      n_checks++; if (bus.disp_rvalid !== (c == 3)) $display("FAIL single_read disp_rvalid c%0d: got %b want %b", c, bus.disp_rvalid, c == 3); else n_pass++;
      n_checks++; if (bus.ed_rvalid !== 1'b0) $display("FAIL single_read ed_rvalid c%0d: got %b want 0", c, bus.ed_rvalid); else n_pass++;
      if (c == 1) begin
        n_checks++; if (bus.ram_address !== 8'h05) $display("FAIL single_read ram_address: got %h want 05", bus.ram_address); else n_pass++;
        n_checks++; if (bus.ram_wren !== 1'b0) $display("FAIL single_read ram_wren: got %b want 0", bus.ram_wren); else n_pass++;
      end
      if (c == 3) begin
        n_checks++; if (bus.disp_rdata !== line_pat(8'h05)) $display("FAIL single_read disp_rdata: got %h want %h", bus.disp_rdata[63:0], line_pat(8'h05) & 64'hFFFF_FFFF_FFFF_FFFF); else n_pass++;
      end
      next_cycle();
    end
    set_idle();
  endtask

  task automatic test_write_then_read();
    logic [LINE_W-1:0] wline;
    wline = {320{8'hAA}};
    for (int c = 0; c < 8; c++) begin
      set_idle();
      if (c == 0) begin
        bus.ed_req   = 1'b1;
        bus.ed_we    = 1'b1;
        bus.ed_addr  = 8'h03;
        bus.ed_wdata = wline;
      end else if (c == 1) begin
        bus.disp_req  = 1'b1;
        bus.disp_addr = 8'h03;
      end
      @(negedge clk);
      n_checks++; if (bus.ed_gnt !== (c == 0)) $display("FAIL wr_rd ed_gnt c%0d: got %b want %b", c, bus.ed_gnt, c == 0); else n_pass++;
      n_checks++; if (bus.disp_gnt !== (c == 1)) $display("FAIL wr_rd disp_gnt c%0d: got %b want %b", c, bus.disp_gnt, c == 1); else n_pass++;
      n_checks++; if (bus.ram_wren !== (c == 1)) $display("FAIL wr_rd ram_wren c%0d: got %b want %b", c, bus.ram_wren, c == 1); else n_pass++;
      n_checks++; if (bus.ed_rvalid !== 1'b0) $display("FAIL wr_rd ed_rvalid c%0d: got %b want 0", c, bus.ed_rvalid); else n_pass++;
      n_checks++; if (bus.disp_rvalid !== (c == 4)) $display("FAIL wr_rd disp_rvalid c%0d: got %b want %b", c, bus.disp_rvalid, c == 4); else n_pass++;
      if (c == 1) begin
        n_checks++; if (bus.ram_data !== wline) $display("FAIL wr_rd ram_data: got %h want aa..", bus.ram_data[63:0]); else n_pass++;
      end
      if (c == 4) begin
        n_checks++; if (bus.disp_rdata !== wline) $display("FAIL wr_rd disp_rdata: got %h want aa..", bus.disp_rdata[63:0]); else n_pass++;
      end
      next_cycle();
    end
    set_idle();
  endtask

  task automatic test_contention();
    logic exp_drv;
    for (int c = 0; c < 11; c++) begin
      set_idle();
      bus.disp_req  = (c <= 6);
      bus.disp_addr = 8'h07;
      bus.ed_req    = (c <= 4);
      bus.ed_addr   = 8'h09;
      @(negedge clk);
      exp_drv = (c >= 3 && c <= 9 && c != 7);
      n_checks++; if (bus.disp_gnt !== (c <= 6 && c != 4)) $display("FAIL contention disp_gnt c%0d: got %b want %b", c, bus.disp_gnt, c <= 6 && c != 4); else n_pass++;
      n_checks++; if (bus.ed_gnt !== (c == 4)) $display("FAIL contention ed_gnt c%0d: got %b want %b", c, bus.ed_gnt, c == 4); else n_pass++;
      n_checks++; if (bus.starve_cnt !== ((c < 5) ? 4'(c) : 4'd0)) $display("FAIL contention starve_cnt c%0d: got %0d want %0d", c, bus.starve_cnt, (c < 5) ? c : 0); else n_pass++;
      n_checks++; if (bus.disp_rvalid !== exp_drv) $display("FAIL contention disp_rvalid c%0d: got %b want %b", c, bus.disp_rvalid, exp_drv); else n_pass++;
      n_checks++; if (bus.ed_rvalid !== (c == 7)) $display("FAIL contention ed_rvalid c%0d: got %b want %b", c, bus.ed_rvalid, c == 7); else n_pass++;
      if (exp_drv) begin
        n_checks++; if (bus.disp_rdata !== line_pat(8'h07)) $display("FAIL contention disp_rdata c%0d: got %h", c, bus.disp_rdata[63:0]); else n_pass++;
      end
      if (c == 7) begin
        n_checks++; if (bus.ed_rdata !== line_pat(8'h09)) $display("FAIL contention ed_rdata: got %h", bus.ed_rdata[63:0]); else n_pass++;
      end
      next_cycle();
    end
    set_idle();
  endtask

  task automatic test_interleaved();
    for (int c = 0; c < 8; c++) begin
      set_idle();
      if (c == 0) begin bus.disp_req = 1'b1; bus.disp_addr = 8'h01; end
      if (c == 1) begin bus.ed_req = 1'b1; bus.ed_addr = 8'h02; end
      if (c == 2) begin bus.disp_req = 1'b1; bus.disp_addr = 8'h04; end
      @(negedge clk);
      n_checks++; if (bus.disp_gnt !== (c == 0 || c == 2)) $display("FAIL interleave disp_gnt c%0d: got %b", c, bus.disp_gnt); else n_pass++;
      n_checks++; if (bus.ed_gnt !== (c == 1)) $display("FAIL interleave ed_gnt c%0d: got %b", c, bus.ed_gnt); else n_pass++;
      n_checks++; if (bus.disp_rvalid !== (c == 3 || c == 5)) $display("FAIL interleave disp_rvalid c%0d: got %b", c, bus.disp_rvalid); else n_pass++;
      n_checks++; if (bus.ed_rvalid !== (c == 4)) $display("FAIL interleave ed_rvalid c%0d: got %b", c, bus.ed_rvalid); else n_pass++;
      n_checks++; if ((bus.disp_rvalid & bus.ed_rvalid) !== 1'b0) $display("FAIL interleave both_rvalid c%0d: got 1 want 0", c); else n_pass++;
      if (c == 3) begin
        n_checks++; if (bus.disp_rdata !== line_pat(8'h01)) $display("FAIL interleave disp_rdata c3: got %h", bus.disp_rdata[63:0]); else n_pass++;
      end
      if (c == 4) begin
        n_checks++; if (bus.ed_rdata !== line_pat(8'h02)) $display("FAIL interleave ed_rdata c4: got %h", bus.ed_rdata[63:0]); else n_pass++;
      end
      if (c == 5) begin
        n_checks++; if (bus.disp_rdata !== line_pat(8'h04)) $display("FAIL interleave disp_rdata c5: got %h", bus.disp_rdata[63:0]); else n_pass++;
      end
      next_cycle();
    end
    set_idle();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 7; c++) begin
      set_idle();
      bus.ed_req  = (c <= 2);
      bus.ed_addr = 8'(20 + c);
      @(negedge clk);
      n_checks++; if (bus.ed_gnt !== (c <= 2)) $display("FAIL b2b ed_gnt c%0d: got %b", c, bus.ed_gnt); else n_pass++;
      n_checks++; if (bus.ed_rvalid !== (c >= 3 && c <= 5)) $display("FAIL b2b ed_rvalid c%0d: got %b", c, bus.ed_rvalid); else n_pass++;
      n_checks++; if (bus.disp_rvalid !== 1'b0) $display("FAIL b2b disp_rvalid c%0d: got %b want 0", c, bus.disp_rvalid); else n_pass++;
      if (c >= 3 && c <= 5) begin
        n_checks++; if (bus.ed_rdata !== line_pat(8'(17 + c))) $display("FAIL b2b ed_rdata c%0d: got %h", c, bus.ed_rdata[63:0]); else n_pass++;
      end
      next_cycle();
    end
    set_idle();
  endtask

  task automatic test_reset_mid_flight();
    for (int c = 0; c < 7; c++) begin
      set_idle();
      rst = (c == 1);
      if (c <= 1) begin bus.disp_req = 1'b1; bus.disp_addr = 8'h06; end
      if (c == 1) bus.ed_req = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.disp_rvalid !== 1'b0) $display("FAIL rst_mid disp_rvalid c%0d: got %b want 0", c, bus.disp_rvalid); else n_pass++;
      if (c == 1) begin
        n_checks++; if ({bus.disp_gnt, bus.ed_gnt} !== 2'b00) $display("FAIL rst_mid gnt: got %b want 00", {bus.disp_gnt, bus.ed_gnt}); else n_pass++;
        n_checks++; if (bus.ram_address !== 8'h06) $display("FAIL rst_mid ram_address c1: got %h want 06", bus.ram_address); else n_pass++;
      end
      if (c == 2) begin
        n_checks++; if (bus.ram_wren !== 1'b0) $display("FAIL rst_mid ram_wren: got %b want 0", bus.ram_wren); else n_pass++;
        n_checks++; if (bus.starve_cnt !== 4'd0) $display("FAIL rst_mid starve_cnt: got %0d want 0", bus.starve_cnt); else n_pass++;
        n_checks++; if (bus.ram_address !== 8'h00) $display("FAIL rst_mid ram_address c2: got %h want 00", bus.ram_address); else n_pass++;
      end
      next_cycle();
    end
    rst = 1'b0;
    set_idle();
  endtask

  task automatic test_starve_release();
    int exp_sc [11] = '{0, 1, 2, 0, 1, 2, 3, 4, 0, 0, 0};
    logic exp_drv;
    for (int c = 0; c < 11; c++) begin
      set_idle();
      bus.disp_req  = (c <= 8);
      bus.disp_addr = 8'h0B;
      bus.ed_req    = (c <= 1) || (c >= 3 && c <= 7);
      bus.ed_addr   = 8'h0C;
      @(negedge clk);
      exp_drv = (c >= 3 && c != 10);
      n_checks++; if (bus.starve_cnt !== 4'(exp_sc[c])) $display("FAIL starve_rel starve_cnt c%0d: got %0d want %0d", c, bus.starve_cnt, exp_sc[c]); else n_pass++;
      n_checks++; if (bus.ed_gnt !== (c == 7)) $display("FAIL starve_rel ed_gnt c%0d: got %b want %b", c, bus.ed_gnt, c == 7); else n_pass++;
      n_checks++; if (bus.disp_gnt !== (c <= 8 && c != 7)) $display("FAIL starve_rel disp_gnt c%0d: got %b", c, bus.disp_gnt); else n_pass++;
      n_checks++; if (bus.disp_rvalid !== exp_drv) $display("FAIL starve_rel disp_rvalid c%0d: got %b want %b", c, bus.disp_rvalid, exp_drv); else n_pass++;
      n_checks++; if (bus.ed_rvalid !== (c == 10)) $display("FAIL starve_rel ed_rvalid c%0d: got %b", c, bus.ed_rvalid); else n_pass++;
      if (c == 10) begin
        n_checks++; if (bus.ed_rdata !== line_pat(8'h0C)) $display("FAIL starve_rel ed_rdata: got %h", bus.ed_rdata[63:0]); else n_pass++;
      end
      next_cycle();
    end
    set_idle();
    repeat (4) next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_then_read();
    test_contention();
    test_interleaved();
    test_back_to_back();
    test_reset_mid_flight();
    test_starve_release();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
